uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter core among `N_REQ` byte-producing clients. It latches the winning client's byte and framing settings (parity select, stop-bit select), and launches the transmitter with a one-cycle start pulse. It then holds ownership until the transmitter reports frame completion, and rotates priority afterwards. It sits between the client request logic and the UART TX datapath, in the same way the RX controller sits in front of the RX shift register.

## Interface

Clock and reset: `clk`, with `reset` asynchronous and active-high.

Parameters:
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `TIMEOUT_W`, default 16: timeout counter width. Used only when `UART_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  N_REQ: per-client level request. Must stay high until `ack`.
- `req_data`  in  8*N_REQ: client i byte on bits [8i+7:8i].
- `req_parity_sel`  in  N_REQ: per-client parity select (1 = even, 0 = odd).
- `req_stop_sel`  in  N_REQ: per-client stop select (1 = two stop bits).
- `ack`  out  N_REQ: one-hot, one-cycle pulse telling the client its byte was launched.
- `grant`  out  N_REQ: one-hot current owner, held from launch through completion.
- `tx_data`  out  8: latched byte for the transmitter.
- `tx_parity_sel`, `tx_stop_sel`  out  1 each: latched framing settings.
- `tx_start`  out  1: one-cycle launch pulse.
- `tx_busy`  in  1: transmitter is busy and cannot accept `tx_start`.
- `tx_done`  in  1: one-cycle pulse marking the end of the final stop bit.
- `timeout_limit`  in  TIMEOUT_W: present only with `UART_ARB_TIMEOUT_EN`. Value 0 disables the watchdog.
- `timeout_err`  out  1: present only with `UART_ARB_TIMEOUT_EN`. One-cycle pulse.

## Operation

- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - If `req != 0`, pick the first set bit at or after `rr_ptr`, wrapping from `N_REQ-1` to 0.
  - Latch the owner index, byte and framing settings, then go to LAUNCH.
  - If `req == 0`, stay in IDLE.
- LAUNCH:
  - `grant` is asserted for the owner.
  - If `tx_busy == 0`, assert `tx_start` and `ack[owner]` for exactly this cycle, then go to WAIT.
  - Otherwise stay in LAUNCH with `tx_start` low.
- WAIT:
  - On `tx_done`: set `rr_ptr <= (owner+1) mod N_REQ`, clear `grant`, go to IDLE.
- `tx_data`, `tx_parity_sel` and `tx_stop_sel` are registered. They are stable from LAUNCH entry until the next latch.
- Latched values are immune to client changes: once latched, changes to `req`, data or settings have no effect on the current transfer.
- `tx_done` received in IDLE or LAUNCH is ignored as stale.
- All outputs are registered. Reset values:
  - `grant`, `ack`, `tx_start`, `tx_data`, `tx_parity_sel`, `tx_stop_sel`, `timeout_err`: all 0.
  - `rr_ptr`: 0.
  - State: IDLE.
- Reset in the middle of a transfer returns the block to IDLE immediately. The TX core is reset separately, and no `ack` is reissued.

## Timing

- Request to launch:
  - `req` is seen in IDLE at cycle t.
  - LAUNCH with `grant`, `tx_start` and `ack` occurs at t+1, provided `tx_busy` is low.
- Completion to next launch:
  - `tx_done` arrives at cycle k.
  - IDLE at k+1, next LAUNCH at k+2. The minimum gap between frames is 2 idle cycles.
- Exactly one `tx_start` per grant. `ack` and `tx_start` are always coincident.
- Priority wrap: with owner `N_REQ-1`, `rr_ptr` becomes 0.
- Simultaneous requests: the lowest index at or after `rr_ptr` wins. Every persistent requester is served within `N_REQ` frames.

## Configuration

- `UART_ARB_TIMEOUT_EN` defined:
  - A `TIMEOUT_W`-bit counter clears on WAIT entry and increments each WAIT cycle.
  - If the counter reaches `timeout_limit` (non-zero) before `tx_done`, pulse `timeout_err` for one cycle. Then advance `rr_ptr` as on normal completion and return to IDLE.
  - If `tx_done` and the timeout occur in the same cycle, `tx_done` wins and no error is raised.
- `UART_ARB_TIMEOUT_EN` undefined:
  - No counter, no `timeout_limit` or `timeout_err` ports.
  - WAIT holds indefinitely until `tx_done`.

## Structure

- Package `uart_arb_pkg` holds:
  - The `arb_state_t` enum (IDLE, LAUNCH, WAIT).
  - `MAX_REQ = 8`.
  - The default `TIMEOUT_W` constant.
- Sub-module `uart_rr_pick` is purely combinational. Inputs: `req`, `rr_ptr`. Outputs: `valid`, one-hot `pick`, `pick_idx`.
- The FSM, latches and watchdog live in the top module.

## Test plan

- `req=4'b0001`, `req_data[7:0]=8'hA5`, `tx_busy=0` → at the next cycle `grant=0001`, `tx_start=1`, `ack=0001`, `tx_data=A5`. After `tx_done`, IDLE, with `rr_ptr=1`.
- `req=4'b1111` held, with `tx_done` three cycles after each start → grant order 0,1,2,3,0. Each launch occurs 2 cycles after the prior `tx_done`.
- Owner 3 completes → `rr_ptr=0`. With `req=4'b1001` next, grant goes to 0.
- LAUNCH with `tx_busy=1` for 5 cycles → no `tx_start` or `ack` during those cycles. When `tx_busy` falls, exactly one `tx_start`.
- With the timeout feature enabled, `timeout_limit=10`, and no `tx_done` → `timeout_err` pulses once, the block returns to IDLE, and `rr_ptr` advances. A stray `tx_done` in IDLE is ignored.
- Reset asserted during WAIT → all outputs 0 within the same cycle. After release, a pending `req=4'b0100` is granted first.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } arb_state_t;

  localparam int unsigned MAX_REQ           = 8;
  localparam int unsigned TIMEOUT_W_DEFAULT = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping to 0.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic             hi_hit;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Lowest requester at/above the pointer wins; otherwise the lowest overall (wrap).
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= rr_ptr) begin
          hi_idx = IDX_W'(i);
          hi_hit = 1'b1;
        end
      end
    end
  end

  assign valid    = |req;
  assign pick_idx = hi_hit ? hi_idx : lo_idx;
  assign pick     = valid ? (N_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART TX core among N_REQ clients.
// Optional watchdog on the WAIT state enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [8*N_REQ-1:0]     req_data,
  input  logic [N_REQ-1:0]       req_parity_sel,
  input  logic [N_REQ-1:0]       req_stop_sel,
  input  logic                   tx_busy,
  input  logic                   tx_done,
`ifdef UART_ARB_TIMEOUT_EN
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  output logic                   timeout_err,
`endif
  output logic [N_REQ-1:0]       ack,
  output logic [N_REQ-1:0]       grant,
  output logic [7:0]             tx_data,
  output logic                   tx_parity_sel,
  output logic                   tx_stop_sel,
  output logic                   tx_start
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  // An out-of-range configuration never grants rather than misbehaving silently.
  localparam logic        CFG_OK = (N_REQ >= 2) && (N_REQ <= MAX_REQ) && (TIMEOUT_W >= 1);

  arb_state_t       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] ack_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;
  logic             tx_parity_q;
  logic             tx_stop_q;

  logic             pick_valid;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic [7:0]       sel_byte_c;
  logic             sel_parity_c;
  logic             sel_stop_c;
  logic             done_c;
  logic             timeout_c;
  logic [IDX_W-1:0] ptr_next_c;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr_q),
    .valid    (pick_valid),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    sel_byte_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_byte_c = sel_byte_c | (req_data[8*i +: 8] & {8{pick[i]}});
    end
  end

  assign sel_parity_c = |(req_parity_sel & pick);
  assign sel_stop_c   = |(req_stop_sel & pick);
  // A done coinciding with our own start pulse belongs to an earlier frame.
  assign done_c       = (state_q == WAIT) && tx_done && !tx_start_q;
  assign ptr_next_c   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_parity_q <= 1'b0;
      tx_stop_q   <= 1'b0;
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid && CFG_OK) begin
            owner_q     <= pick_idx;
            grant_q     <= pick;
            tx_data_q   <= sel_byte_c;
            tx_parity_q <= sel_parity_c;
            tx_stop_q   <= sel_stop_c;
            if (!tx_busy) begin
              tx_start_q <= 1'b1;
              ack_q      <= pick;
              state_q    <= WAIT;
            end else begin
              state_q <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            ack_q      <= grant_q;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (done_c || timeout_c) begin
            grant_q  <= '0;
            rr_ptr_q <= ptr_next_c;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt_q;
  logic                 timeout_err_q;

  // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
  assign timeout_c = (state_q == WAIT) && !done_c && (timeout_limit != '0) &&
                     ((to_cnt_q + TIMEOUT_W'(1)) == timeout_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_c;
      if (state_q != WAIT) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_c = 1'b0;
`endif

  assign ack           = ack_q;
  assign grant         = grant_q;
  assign tx_start      = tx_start_q;
  assign tx_data       = tx_data_q;
  assign tx_parity_sel = tx_parity_q;
  assign tx_stop_sel   = tx_stop_q;

endmodule
